// File: rtl/bus_master_wrapper.sv
// bus_master_wrapper: initiator-side bridge from the core load/store port to
// the single-slave memory bus. It runs one request at a time as an address
// phase followed by a data phase, and stretches either phase while HReady is low.
module bus_master_wrapper #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Creq,
    input  logic        Cwrite,
    input  logic [31:0] CAddress,
    input  logic [31:0] CWrite_data,
    output logic [31:0] CRead_data,
    output logic [1:0]  Cerr_code,
    output logic        Cdone,
    output logic        Cstall,
    output logic [31:0] HAddress,
    output logic        HWrite,
    output logic [1:0]  HTrans,
    output logic [31:0] HWrite_data,
    input  logic [31:0] HRead_data,
    input  logic [1:0]  HResp,
    input  logic        HReady
);

    localparam int unsigned DW        = 32;
    localparam int unsigned CW        = $clog2(TIMEOUT) + 1;
    localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam bit            TO_EN   = (TIMEOUT != 0);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_SLAVE     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_haddr;
    logic            r_hwrite;
    logic [DW-1:0]   r_hwdata;
    logic [DW-1:0]   r_crdata;
    logic [1:0]      r_cerr;
    logic            r_cdone;
    logic [1:0]      r_htrans;

    logic            w_latch;
    logic            w_cnt_clr;
    logic            w_cnt_inc;
    logic            w_timeout;
    logic            w_data_done;
    logic            w_expired;

    // A phase aborts on the low-HReady cycle that finds the counter at its last value
    assign w_expired = TO_EN && !HReady && (r_cnt == TO_LAST);

    // Next-state and per-cycle control decode
    always_comb begin
        w_next      = r_state;
        w_latch     = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_timeout   = 1'b0;
        w_data_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Creq) begin
                    w_latch   = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_next    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (HReady) begin
                    w_cnt_clr = 1'b1;
                    w_next    = S_DATA;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_DATA: begin
                if (HReady) begin
                    w_data_done = 1'b1;
                    w_next      = S_RESP;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Saturating wait-state counter, cleared at each phase entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             r_cnt <= '0;
        else if (w_cnt_clr)                   r_cnt <= '0;
        else if (w_cnt_inc && r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
    end

    // Request fields captured once in IDLE; they double as the bus-side registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_haddr  <= '0;
            r_hwrite <= 1'b0;
            r_hwdata <= '0;
        end else if (w_latch) begin
            r_haddr  <= CAddress;
            r_hwrite <= Cwrite;
            r_hwdata <= CWrite_data;
        end
    end

    // HTrans and Cdone follow the state being entered so they line up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_htrans <= HTRANS_IDLE;
            r_cdone  <= 1'b0;
        end else begin
            r_htrans <= (w_next == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
            r_cdone  <= (w_next == S_RESP);
        end
    end

    // Completion status and read data; read data only moves on a clean read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cerr   <= ERR_OK;
            r_crdata <= '0;
        end else if (w_timeout) begin
            r_cerr <= ERR_TIMEOUT;
        end else if (w_data_done) begin
            r_cerr <= (HResp == 2'b00) ? ERR_OK : ERR_SLAVE;
            if (!r_hwrite && HResp == 2'b00) r_crdata <= HRead_data;
        end
    end

    assign Cstall      = Creq && (r_state != S_RESP);
    assign CRead_data  = r_crdata;
    assign Cerr_code   = r_cerr;
    assign Cdone       = r_cdone;
    assign HAddress    = r_haddr;
    assign HWrite      = r_hwrite;
    assign HTrans      = r_htrans;
    assign HWrite_data = r_hwdata;

endmodule

// File: tb/tb_bus_master_wrapper.sv
// Bench for bus_master_wrapper: scripted slave, per-cycle bus checks and a
// scoreboard of expected completions popped on every Cdone.
module tb_bus_master_wrapper;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst;
    logic        Creq;
    logic        Cwrite;
    logic [31:0] CAddress;
    logic [31:0] CWrite_data;
    logic [31:0] CRead_data;
    logic [1:0]  Cerr_code;
    logic        Cdone;
    logic        Cstall;
    logic [31:0] HAddress;
    logic        HWrite;
    logic [1:0]  HTrans;
    logic [31:0] HWrite_data;
    logic [31:0] HRead_data;
    logic [1:0]  HResp;
    logic        HReady;

    bus_master_wrapper #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .Creq       (Creq),
        .Cwrite     (Cwrite),
        .CAddress   (CAddress),
        .CWrite_data(CWrite_data),
        .CRead_data (CRead_data),
        .Cerr_code  (Cerr_code),
        .Cdone      (Cdone),
        .Cstall     (Cstall),
        .HAddress   (HAddress),
        .HWrite     (HWrite),
        .HTrans     (HTrans),
        .HWrite_data(HWrite_data),
        .HRead_data (HRead_data),
        .HResp      (HResp),
        .HReady     (HReady)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] model_rd;
    int          n_checks;
    int          n_fail;
    int          n_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every completion must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst && Cdone) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_cdone", 32'(Cdone), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_rdata", CRead_data, mon_e.rdata);
                chk("sb_err_code", 32'(Cerr_code), 32'(mon_e.err));
            end
        end
    end

    // One CPU transfer: aw/dw are HReady-low cycles in ADDR/DATA (>= TO forces a timeout)
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int aw, input int dw, input logic [1:0] resp,
                        input logic [31:0] rdata, input bit keep_req, input string name);
        int       a_end;
        int       d_end;
        int       exp_done;
        bit       to;
        bit       in_a;
        bit       in_d;
        logic [1:0] err;
        to       = (aw >= int'(TO)) || (dw >= int'(TO));
        a_end    = (aw >= int'(TO)) ? int'(TO) : aw + 1;
        d_end    = (aw >= int'(TO)) ? a_end : a_end + ((dw >= int'(TO)) ? int'(TO) : dw + 1);
        exp_done = d_end + 1;
        err      = to ? 2'b10 : ((resp != 2'b00) ? 2'b01 : 2'b00);
        if (!to && resp == 2'b00 && !wr) model_rd = rdata;

        next_cycle();
        Creq        = 1'b1;
        Cwrite      = wr;
        CAddress    = addr;
        CWrite_data = wdata;
        HReady      = 1'b1;
        HResp       = 2'b11;
        HRead_data  = ~rdata;
        sb.push_back('{rdata: model_rd, err: err});
        in_a = 1'b0;
        in_d = 1'b0;
        for (int c = 0; c <= exp_done; c++) begin
            if (c > 0) begin
                next_cycle();
                CAddress    = ~addr;
                CWrite_data = ~wdata;
                Cwrite      = ~wr;
                in_a        = (c <= a_end);
                in_d        = (c > a_end) && (c <= d_end);
                if (in_a)      HReady = (c - 1 >= aw) ? 1'b1 : 1'b0;
                else if (in_d) HReady = (c - a_end - 1 >= dw) ? 1'b1 : 1'b0;
                else           HReady = 1'b1;
                HResp      = in_d ? resp : 2'b11;
                HRead_data = in_d ? rdata : ~rdata;
            end
            #1;
            chk({name, "_cdone"}, 32'(Cdone), 32'(c == exp_done));
            chk({name, "_cstall"}, 32'(Cstall), 32'(c != exp_done));
            chk({name, "_htrans"}, 32'(HTrans), in_a ? 32'd2 : 32'd0);
            if (in_a) begin
                chk({name, "_haddr"}, HAddress, addr);
                chk({name, "_hwrite"}, 32'(HWrite), 32'(wr));
            end
            if (in_d) begin
                chk({name, "_haddr_hold"}, HAddress, addr);
                chk({name, "_hwdata"}, HWrite_data, wdata);
            end
        end
        if (!keep_req) begin
            next_cycle();
            Creq = 1'b0;
            #1;
            chk({name, "_idle_htrans"}, 32'(HTrans), 32'd0);
            chk({name, "_idle_cdone"}, 32'(Cdone), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_done=%0d expected 9", n_done);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        n_done      = 0;
        model_rd    = 32'h0;
        rst         = 1'b0;
        Creq        = 1'b0;
        Cwrite      = 1'b0;
        CAddress    = 32'h0;
        CWrite_data = 32'h0;
        HRead_data  = 32'h0;
        HResp       = 2'b00;
        HReady      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_htrans", 32'(HTrans), 32'd0);
        chk("rst_haddr", HAddress, 32'h0);
        chk("rst_hwrite", 32'(HWrite), 32'd0);
        chk("rst_hwdata", HWrite_data, 32'h0);
        chk("rst_crdata", CRead_data, 32'h0);
        chk("rst_cerr", 32'(Cerr_code), 32'd0);
        chk("rst_cdone", 32'(Cdone), 32'd0);
        rst = 1'b1;

        xfer(1'b0, 32'h0000_0040, 32'h0,         0, 0, 2'b00, 32'hDEAD_BEEF, 1'b0, "rd0");
        xfer(1'b1, 32'h0000_0100, 32'h1234_5678, 0, 2, 2'b00, 32'hCAFE_F00D, 1'b0, "wr_wait");
        xfer(1'b0, 32'h0000_0200, 32'h0,         1, 0, 2'b01, 32'h55AA_55AA, 1'b0, "serr");
        xfer(1'b0, 32'h0000_0300, 32'h0,         4, 0, 2'b00, 32'h1111_1111, 1'b0, "to_addr");
        xfer(1'b1, 32'h0000_0304, 32'hA5A5_A5A5, 0, 4, 2'b00, 32'h2222_2222, 1'b0, "to_data");
        xfer(1'b0, 32'h0000_0400, 32'h0,         0, 0, 2'b00, 32'h0BAD_CAFE, 1'b1, "b2b_a");
        xfer(1'b0, 32'h0000_0404, 32'h0,         1, 1, 2'b00, 32'h600D_F00D, 1'b0, "b2b_b");
        xfer(1'b0, 32'h0000_0500, 32'h0,         0, 1, 2'b10, 32'h3333_3333, 1'b0, "serr2");
        chk("pre_reset_sb_empty", 32'(sb.size()), 32'd0);

        // Abort a write in its DATA phase with an asynchronous reset
        next_cycle();
        Creq        = 1'b1;
        Cwrite      = 1'b1;
        CAddress    = 32'h0000_0600;
        CWrite_data = 32'h0000_0077;
        HReady      = 1'b1;
        HResp       = 2'b00;
        next_cycle();
        #1;
        chk("ar_addr_htrans", 32'(HTrans), 32'd2);
        next_cycle();
        HReady = 1'b0;
        #1;
        chk("ar_data_hwdata", HWrite_data, 32'h0000_0077);
        rst = 1'b0;
        #1;
        chk("ar_htrans", 32'(HTrans), 32'd0);
        chk("ar_haddr", HAddress, 32'h0);
        chk("ar_hwrite", 32'(HWrite), 32'd0);
        chk("ar_hwdata", HWrite_data, 32'h0);
        chk("ar_crdata", CRead_data, 32'h0);
        chk("ar_cerr", 32'(Cerr_code), 32'd0);
        chk("ar_cdone", 32'(Cdone), 32'd0);
        Creq     = 1'b0;
        HReady   = 1'b1;
        model_rd = 32'h0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk("ar_post_cdone", 32'(Cdone), 32'd0);
            chk("ar_post_htrans", 32'(HTrans), 32'd0);
        end
        xfer(1'b0, 32'h0000_0700, 32'h0, 0, 0, 2'b00, 32'h4444_4444, 1'b0, "post_rst");

        repeat (2) next_cycle();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_done_count", 32'(n_done), 32'd9);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_master_wrapper.md
# bus_master_wrapper

- Initiator-side bridge between the core's load/store port and the single-slave memory bus.
- Accepts one CPU request at a time and runs a two-phase bus transfer: an address phase, then a data phase.
- Stretches both phases while HReady is low and returns read data plus an error code to the core.
- Sits between the core and the memory-side slave wrapper, and drives exactly the signals that wrapper consumes.

## Interface
Parameters:
- TIMEOUT, 16 — consecutive HReady-low cycles within one phase before the transfer is aborted; 0 disables the timeout.

Ports:
- clk  input  1  — single clock; all state updates on its rising edge.
- rst  input  1  — asynchronous, active-low reset.
- Creq  input  1  — CPU request; held high until Cdone.
- Cwrite  input  1  — 1 = write, 0 = read.
- CAddress  input  32  — request address.
- CWrite_data  input  32  — write data.
- CRead_data  output  32  — registered read data; valid when Cdone=1.
- Cerr_code  output  2  — 00 OK, 01 slave error, 10 timeout; valid when Cdone=1.
- Cdone  output  1  — one-cycle completion pulse.
- Cstall  output  1  — tells the core to hold the pipeline.
- HAddress  output  32  — bus address; meaningful in the address phase.
- HWrite  output  1  — bus direction; meaningful in the address phase.
- HTrans  output  2  — 00 IDLE, 10 NONSEQ.
- HWrite_data  output  32  — bus write data; meaningful in the data phase.
- HRead_data  input  32  — slave read data.
- HResp  input  2  — slave response; 00 OKAY, any nonzero value is an error.
- HReady  input  1  — slave ready.

## Operation
FSM states: IDLE, ADDR, DATA, RESP.
- IDLE
  - HTrans=00.
  - If Creq=1 at an edge: latch CAddress, Cwrite and CWrite_data into internal registers; clear the wait counter; go to ADDR.
- ADDR
  - HTrans=10; HAddress and HWrite are driven from the latched values.
  - HReady=1 at an edge: clear the wait counter; go to DATA.
  - HReady=0: increment the wait counter.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with HReady=0: Cerr_code←10; go to RESP.
- DATA
  - HTrans=00; HWrite_data is driven from the latched write data.
  - HReady=1 at an edge:
    - if the transfer is a read, CRead_data←HRead_data;
    - Cerr_code←(HResp==00 ? 00 : 01);
    - go to RESP.
  - HReady=0: same counting and timeout rule as ADDR.
- RESP
  - Cdone=1 for exactly one cycle.
  - Always go to IDLE; the request is never re-sampled in RESP.

Output rules:
- Cstall = Creq && (state ≠ RESP), combinational.
- CRead_data holds until the next successful read completes. It is not updated on writes, on timeouts, or on slave-error reads.
- Cerr_code holds until the next RESP.
- HAddress, HWrite and HWrite_data are registered and hold their values between transfers.
- Latched request fields do not change after leaving IDLE, even if the CPU inputs change.
- The wait counter is $clog2(TIMEOUT)+1 bits wide and saturates; it never wraps.

## Timing
Reset (rst=0, asynchronous):
- state=IDLE, HTrans=00.
- HAddress, HWrite_data, CRead_data, the latched fields and the counter = 0.
- HWrite=0, Cerr_code=00, Cdone=0.

Zero-wait transfer (Creq high in cycle 0):
- Cycle 1: ADDR.
- Cycle 2: DATA.
- Cycle 3: RESP, with Cdone=1 and data/code valid.
- Cycle 4: IDLE.
- Minimum 4 cycles per transfer.
- Each HReady-low cycle adds one cycle to its phase.

Back-to-back requests:
- A request held high through RESP is taken as a new request in IDLE at cycle 4.
- Its ADDR phase starts in cycle 5.

Reset mid-transfer:
- The transfer is abandoned immediately: HTrans=00, no Cdone.
- After rst deasserts, the FSM starts from IDLE.

HResp is sampled only in DATA with HReady=1; it is ignored in every other state.

## Test plan
- **Zero-wait read.** CAddress=0x0000_0040, Cwrite=0, slave HReady=1, HRead_data=0xDEAD_BEEF. Required:
  - HTrans=10 with HAddress=0x40 in cycle 1;
  - Cdone=1 in cycle 3 with CRead_data=0xDEADBEEF and Cerr_code=00;
  - Cstall=1 in cycles 0–2 and 0 in cycle 3.
- **Wait-state write.** Write 0x1234_5678 to 0x100, HReady=0 for 2 DATA cycles. Required:
  - HWrite=1 in ADDR;
  - HWrite_data=0x12345678 held through all 3 DATA cycles;
  - Cdone in cycle 5;
  - CRead_data unchanged.
- **Slave error.** HResp=01 with HReady=1 in DATA on a read. Required: Cerr_code=01 at Cdone, and CRead_data keeps its previous value.
- **Timeout.** TIMEOUT=4, HReady held 0 in ADDR. Required: RESP entered after the 4th low cycle with Cerr_code=10, then HTrans=00.
- **Back-to-back plus stability.** Two reads with Creq held continuously, and CAddress changed mid-transfer. Required:
  - the first transfer uses the latched address;
  - the second ADDR phase starts in cycle 5;
  - exactly one Cdone per transfer.
- **Async reset.** Drop rst in DATA. Required: HTrans=00 and the state is IDLE before the next clk edge, with all outputs at their reset values and no Cdone.
